crop_bbox_detect: RTL and testbench

- Parametrised successor to the single-edge Y-start cropper in the capture pipeline.
- Scans a raster frame pixel by pixel on iDVAL and tests pixels inside a programmable region of interest (ROI) against a threshold.
- Reports the bounding box of all matching ("dark") pixels once per frame: first/last row, first/last column, plus a found flag.
- Sits after the capture/greyscale stage; downstream crop logic consumes the registered box on the oDONE strobe.

---
 rtl/crop_pkg.sv | 21 ++
 rtl/raster_counter.sv | 43 ++++
 rtl/crop_bbox_detect.sv | 165 ++++++++++++++++
 tb/tb_crop_bbox_detect.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crop_pkg.sv
// Shared types and default geometry for the crop blocks.
// Frame size, ROI defaults, FSM state type and coordinate type.
package crop_pkg;

    localparam int DEF_DATA_W  = 10;
    localparam int DEF_COORD_W = 16;
    localparam int DEF_FRAME_W = 640;
    localparam int DEF_FRAME_H = 480;
    localparam int DEF_ROI_X0  = 161;
    localparam int DEF_ROI_X1  = 479;
    localparam int DEF_ROI_Y0  = 121;
    localparam int DEF_ROI_Y1  = 189;

    typedef enum logic {
        SCAN   = 1'b0,
        REPORT = 1'b1
    } state_t;

    typedef logic [DEF_COORD_W-1:0] coord_t;

endpackage

// File: rtl/raster_counter.sv
// Raster X/Y position counter with wrap and end-of-frame flag.
// Ports: iCLK, iRST (async active-low), iEn (advance), oX, oY, oLast.
import crop_pkg::*;

module raster_counter #(
    parameter int COORD_W = DEF_COORD_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iEn,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oLast
);

    localparam logic [COORD_W-1:0] XMAX = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] YMAX = COORD_W'(FRAME_H - 1);

    logic endLine;
    logic endFrame;

    assign endLine  = (oX == XMAX);
    assign endFrame = endLine && (oY == YMAX);
    // Flags the position, not the acceptance; caller qualifies with iEn.
    assign oLast    = endFrame;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oX <= '0;
            oY <= '0;
        end else if (iEn) begin
            if (endLine) begin
                oX <= '0;
                oY <= endFrame ? '0 : oY + 1'b1;
            end else begin
                oX <= oX + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crop_bbox_detect.sv
// Per-frame bounding box of ROI pixels at or below a threshold.
// Ports: iCLK, iRST (async low), iDVAL/iDATA/iTHRESH in; oDVAL, oDONE, oFOUND, oX/Y START/END out.
import crop_pkg::*;

module crop_bbox_detect #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COORD_W = DEF_COORD_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int ROI_X0  = DEF_ROI_X0,
    parameter int ROI_X1  = DEF_ROI_X1,
    parameter int ROI_Y0  = DEF_ROI_Y0,
    parameter int ROI_Y1  = DEF_ROI_Y1
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iDVAL,
    input  logic [DATA_W-1:0]  iDATA,
    input  logic [DATA_W-1:0]  iTHRESH,
    output logic               oDVAL,
    output logic               oDONE,
    output logic               oFOUND,
    output logic [COORD_W-1:0] oYSTART,
    output logic [COORD_W-1:0] oYEND,
    output logic [COORD_W-1:0] oXSTART,
    output logic [COORD_W-1:0] oXEND
);

    localparam logic [COORD_W-1:0] RX0 = COORD_W'(ROI_X0);
    localparam logic [COORD_W-1:0] RX1 = COORD_W'(ROI_X1);
    localparam logic [COORD_W-1:0] RY0 = COORD_W'(ROI_Y0);
    localparam logic [COORD_W-1:0] RY1 = COORD_W'(ROI_Y1);

    if (ROI_X1 >= FRAME_W || ROI_Y1 >= FRAME_H) begin : gBadRoiEdge
        $error("ROI exceeds frame");
    end
    if (ROI_X0 > ROI_X1 || ROI_Y0 > ROI_Y1) begin : gBadRoiOrder
        $error("ROI start after ROI end");
    end
    if (64'(FRAME_W) > (64'd1 << COORD_W) ||
        64'(FRAME_H) > (64'd1 << COORD_W)) begin : gBadCoordW
        $error("frame size does not fit COORD_W");
    end

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last;

    raster_counter #(
        .COORD_W(COORD_W),
        .FRAME_W(FRAME_W),
        .FRAME_H(FRAME_H)
    ) uCnt (
        .iCLK (iCLK),
        .iRST (iRST),
        .iEn  (iDVAL),
        .oX   (x),
        .oY   (y),
        .oLast(last)
    );

    // A zero lower bound would be an always-true unsigned compare.
    logic xLo;
    logic yLo;

    if (ROI_X0 == 0) begin : gX0
        assign xLo = 1'b1;
    end else begin : gXn
        assign xLo = (x >= RX0);
    end

    if (ROI_Y0 == 0) begin : gY0
        assign yLo = 1'b1;
    end else begin : gYn
        assign yLo = (y >= RY0);
    end

    logic inRoi;
    logic hit;

    assign inRoi = xLo && (x <= RX1) && yLo && (y <= RY1);
    assign hit   = iDVAL && inRoi && (iDATA <= iTHRESH);

    state_t             state;
    state_t             stateNext;
    logic [COORD_W-1:0] minX, minY, maxX, maxY;
    logic [COORD_W-1:0] minXNext, minYNext, maxXNext, maxYNext;
    logic               found;
    logic               foundNext;

    always_comb begin
        stateNext = state;
        minXNext  = minX;
        minYNext  = minY;
        maxXNext  = maxX;
        maxYNext  = maxY;
        foundNext = found;
        unique case (state)
            SCAN: begin
                if (iDVAL && last) begin
                    stateNext = REPORT;
                end
            end
            REPORT: begin
                stateNext = SCAN;
                minXNext  = '1;
                minYNext  = '1;
                maxXNext  = '0;
                maxYNext  = '0;
                foundNext = 1'b0;
            end
            default: stateNext = SCAN;
        endcase
        // Applied after the REPORT clear so pixel (0,0) of the
        // next frame lands in the fresh working set.
        if (hit) begin
            minXNext  = (x < minXNext) ? x : minXNext;
            minYNext  = (y < minYNext) ? y : minYNext;
            maxXNext  = (x > maxXNext) ? x : maxXNext;
            maxYNext  = (y > maxYNext) ? y : maxYNext;
            foundNext = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= SCAN;
            minX  <= '1;
            minY  <= '1;
            maxX  <= '0;
            maxY  <= '0;
            found <= 1'b0;
        end else begin
            state <= stateNext;
            minX  <= minXNext;
            minY  <= minYNext;
            maxX  <= maxXNext;
            maxY  <= maxYNext;
            found <= foundNext;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL   <= 1'b0;
            oDONE   <= 1'b0;
            oFOUND  <= 1'b0;
            oXSTART <= '0;
            oXEND   <= '0;
            oYSTART <= '0;
            oYEND   <= '0;
        end else begin
            oDVAL <= iDVAL;
            oDONE <= (state == REPORT);
            if (state == REPORT) begin
                oFOUND  <= found;
                oXSTART <= found ? minX : '0;
                oXEND   <= found ? maxX : '0;
                oYSTART <= found ? minY : '0;
                oYEND   <= found ? maxY : '0;
            end
        end
    end

endmodule

// File: tb/tb_crop_bbox_detect.sv
// Scoreboard bench for crop_bbox_detect on an 8x6 frame.
// Two instances: ROI (1..6,1..4) and ROI (0..6,0..4), shared stimulus.
module tb_crop_bbox_detect;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 10;
    localparam int CW = 16;

    typedef struct {
        int     f;
        int     xs;
        int     xe;
        int     ys;
        int     ye;
        longint c;
    } box_t;

    logic          iCLK;
    logic          iRST;
    logic          iDVAL;
    logic [DW-1:0] iDATA;
    logic [DW-1:0] iTHRESH;

    logic          oDval  [2];
    logic          oDone  [2];
    logic          oFound [2];
    logic [CW-1:0] oXs    [2];
    logic [CW-1:0] oXe    [2];
    logic [CW-1:0] oYs    [2];
    logic [CW-1:0] oYe    [2];

    int     nVec = 0;
    int     nErr = 0;
    longint cyc  = 0;
    logic   dvPrev;

    box_t sb   [2][$];
    box_t held [2];
    box_t work [2];
    int   img  [H][W];

    crop_bbox_detect #(
        .DATA_W(DW), .COORD_W(CW), .FRAME_W(W), .FRAME_H(H),
        .ROI_X0(1), .ROI_X1(6), .ROI_Y0(1), .ROI_Y1(4)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
        .iDATA(iDATA), .iTHRESH(iTHRESH),
        .oDVAL(oDval[0]), .oDONE(oDone[0]), .oFOUND(oFound[0]),
        .oYSTART(oYs[0]), .oYEND(oYe[0]),
        .oXSTART(oXs[0]), .oXEND(oXe[0])
    );

    crop_bbox_detect #(
        .DATA_W(DW), .COORD_W(CW), .FRAME_W(W), .FRAME_H(H),
        .ROI_X0(0), .ROI_X1(6), .ROI_Y0(0), .ROI_Y1(4)
    ) dutZ (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
        .iDATA(iDATA), .iTHRESH(iTHRESH),
        .oDVAL(oDval[1]), .oDONE(oDone[1]), .oFOUND(oFound[1]),
        .oYSTART(oYs[1]), .oYEND(oYe[1]),
        .oXSTART(oXs[1]), .oXEND(oXe[1])
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) dvPrev <= 1'b0;
        else       dvPrev <= iDVAL;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit inRoi(input int k, input int x, input int y);
        if (k == 0) return x >= 1 && x <= 6 && y >= 1 && y <= 4;
        return x <= 6 && y <= 4;
    endfunction

    function automatic box_t zeroBox();
        box_t b;
        b.f = 0; b.xs = 0; b.xe = 0; b.ys = 0; b.ye = 0; b.c = 0;
        return b;
    endfunction

    task automatic clearWork();
        for (int k = 0; k < 2; k++) begin
            work[k].f  = 0;
            work[k].xs = 1 << 20;
            work[k].ys = 1 << 20;
            work[k].xe = -1;
            work[k].ye = -1;
            work[k].c  = 0;
        end
    endtask

    task automatic fillImg(input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = v;
    endtask

    // Drives nPix pixels in raster order, gap idle cycles after each.
    task automatic sendFrame(input int th, input int gap, input int nPix);
        int n;
        n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (n < nPix) begin
                    @(negedge iCLK);
                    iDVAL   = 1'b1;
                    iDATA   = DW'(img[y][x]);
                    iTHRESH = DW'(th);
                    for (int k = 0; k < 2; k++) begin
                        if (inRoi(k, x, y) && img[y][x] <= th) begin
                            work[k].f = 1;
                            if (x < work[k].xs) work[k].xs = x;
                            if (x > work[k].xe) work[k].xe = x;
                            if (y < work[k].ys) work[k].ys = y;
                            if (y > work[k].ye) work[k].ye = y;
                        end
                    end
                    if (x == W-1 && y == H-1) begin
                        for (int k = 0; k < 2; k++) begin
                            box_t e;
                            e = zeroBox();
                            if (work[k].f != 0) begin
                                e.f  = 1;
                                e.xs = work[k].xs;
                                e.xe = work[k].xe;
                                e.ys = work[k].ys;
                                e.ye = work[k].ye;
                            end
                            e.c = cyc + 2;
                            sb[k].push_back(e);
                        end
                        clearWork();
                    end
                    for (int g = 0; g < gap; g++) begin
                        @(negedge iCLK);
                        iDVAL = 1'b0;
                    end
                    n++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            iDVAL = 1'b0;
        end
    endtask

    task automatic checkZero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.u%0d.done", tag, k), 64'(oDone[k]), 0);
            check($sformatf("%s.u%0d.found", tag, k), 64'(oFound[k]), 0);
            check($sformatf("%s.u%0d.xs", tag, k), 64'(oXs[k]), 0);
            check($sformatf("%s.u%0d.xe", tag, k), 64'(oXe[k]), 0);
            check($sformatf("%s.u%0d.ys", tag, k), 64'(oYs[k]), 0);
            check($sformatf("%s.u%0d.ye", tag, k), 64'(oYe[k]), 0);
            check($sformatf("%s.u%0d.dval", tag, k), 64'(oDval[k]), 0);
        end
    endtask

    task automatic doReset(input string tag);
        @(negedge iCLK);
        iRST  = 1'b0;
        iDVAL = 1'b0;
        #1;
        checkZero(tag);
        for (int k = 0; k < 2; k++) begin
            sb[k].delete();
            held[k] = zeroBox();
        end
        clearWork();
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
    endtask

    for (genvar k = 0; k < 2; k++) begin : gMon
        always @(negedge iCLK) begin
            if (iRST === 1'b1) begin
                check($sformatf("u%0d.dval", k), 64'(oDval[k]), 64'(dvPrev));
                if (oDone[k] === 1'b1) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("u%0d.spurious_done", k), 1, 0);
                    end else begin
                        box_t e;
                        e = sb[k].pop_front();
                        check($sformatf("u%0d.done_cyc", k), 64'(cyc), 64'(e.c));
                        held[k] = e;
                    end
                end
                check($sformatf("u%0d.found", k), 64'(oFound[k]), 64'(held[k].f));
                check($sformatf("u%0d.xs", k), 64'(oXs[k]), 64'(held[k].xs));
                check($sformatf("u%0d.xe", k), 64'(oXe[k]), 64'(held[k].xe));
                check($sformatf("u%0d.ys", k), 64'(oYs[k]), 64'(held[k].ys));
                check($sformatf("u%0d.ye", k), 64'(oYe[k]), 64'(held[k].ye));
            end
        end
    end

    initial begin
        iRST    = 1'b1;
        iDVAL   = 1'b0;
        iDATA   = '0;
        iTHRESH = '0;
        clearWork();
        for (int k = 0; k < 2; k++) held[k] = zeroBox();
        #2 iRST = 1'b0;
        #1 checkZero("reset");
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;

        // single dark pixel
        fillImg(5);
        img[2][3] = 0;
        sendFrame(0, 0, W*H);
        idle(4);

        // spread box, (7,0) outside both ROIs
        fillImg(5);
        img[1][2] = 0;
        img[4][5] = 0;
        img[3][6] = 0;
        img[0][7] = 0;
        sendFrame(0, 0, W*H);
        idle(4);

        // no match
        fillImg(5);
        sendFrame(4, 0, W*H);
        idle(4);

        // threshold equality at last ROI pixel, stalled input
        fillImg(5);
        img[4][6] = 3;
        sendFrame(3, 2, W*H);
        idle(4);

        // back-to-back; frame 2 pixel (0,0) arrives during REPORT
        fillImg(5);
        img[2][4] = 1;
        sendFrame(2, 0, W*H);
        fillImg(5);
        img[0][0] = 0;
        img[3][5] = 2;
        sendFrame(2, 0, W*H);

        // partial frame with a match, reset at pixel (4,3)
        fillImg(5);
        img[2][2] = 0;
        sendFrame(0, 0, 3*W + 4);
        doReset("midreset");

        // full frame after reset reports only its own box
        fillImg(5);
        img[1][5] = 0;
        sendFrame(0, 0, W*H);

        for (int i = 0; i < 20; i++) begin
            if (sb[0].size() != 0 || sb[1].size() != 0) idle(1);
        end
        idle(2);
        check("u0.drain", 64'(sb[0].size()), 0);
        check("u1.drain", 64'(sb[1].size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
